// File: rtl/bus_pkg.sv
// Shared definitions for the daisy-chained request/response bus cores:
// default widths, rw encoding and the response-merge FSM state type.
package bus_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 16;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    RES_IDLE = 2'd0,
    RES_OWN  = 2'd1,
    RES_FWD  = 2'd2
  } res_state_t;

endpackage

// File: rtl/bus_pipe_reg.sv
// Single-entry valid/ready register slice; accepts a new word whenever it is
// empty or its current word is being taken in the same cycle.
module bus_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_ready) out_valid <= in_valid;
      if (in_valid && in_ready) out_data <= in_data;
    end
  end

endmodule

// File: rtl/bus_lut_ram.sv
// Register-file RAM core on the daisy-chained bus: owns [BASE_ADDR, BASE_ADDR+DEPTH-1],
// forwards other requests, merges its read responses with downstream ones.
// Optional direct storage port enabled by defining BUS_LUT_RAM_USER_PORT_EN.
module bus_lut_ram
  import bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = BUS_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    DEPTH      = 8,
  localparam int                   IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic                  req_rw_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [DATA_WIDTH-1:0] req_data_o,
  output logic                  req_rw_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  input  logic [DATA_WIDTH-1:0] res_data_i,
  input  logic                  res_valid_i,
  output logic                  res_ready_o,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i
`ifdef BUS_LUT_RAM_USER_PORT_EN
  ,
  input  logic [IDX_W-1:0]      user_addr_i,
  input  logic [DATA_WIDTH-1:0] user_data_i,
  input  logic                  user_we_i,
  output logic [DATA_WIDTH-1:0] user_data_o
`endif
);

  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] own_data;
  logic                  own_pend;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic                  hit, hit_acc, hit_wr, hit_rd;
  logic                  pipe_ready;
  res_state_t            state, state_next;
  logic                  can_fwd, load_own, load_fwd, clr_own;

  // Wrapping subtraction: addresses below BASE_ADDR land far above DEPTH.
  assign offset  = req_addr_i - BASE_ADDR;
  assign hit     = {1'b0, offset} < SPAN;
  assign idx     = offset[IDX_W-1:0];
  assign hit_acc = req_valid_i && hit && !own_pend;
  assign hit_wr  = hit_acc && (req_rw_i == RW_WRITE);
  assign hit_rd  = hit_acc && (req_rw_i == RW_READ);

  assign req_ready_o = hit ? !own_pend : pipe_ready;

  bus_pipe_reg #(
    .WIDTH(ADDR_WIDTH + DATA_WIDTH + 1)
  ) u_req_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  ({req_addr_i, req_data_i, req_rw_i}),
    .in_valid (req_valid_i && !hit),
    .in_ready (pipe_ready),
    .out_data ({req_addr_o, req_data_o, req_rw_o}),
    .out_valid(req_valid_o),
    .out_ready(req_ready_i)
  );

  // Storage has no reset so its contents survive rst_n; bus write is last and wins.
  always_ff @(posedge clk) begin
`ifdef BUS_LUT_RAM_USER_PORT_EN
    if (user_we_i) mem[user_addr_i] <= user_data_i;
`endif
    if (hit_wr) mem[idx] <= req_data_i;
    if (hit_rd) own_data <= mem[idx];
  end

`ifdef BUS_LUT_RAM_USER_PORT_EN
  assign user_data_o = mem[user_addr_i];
`endif

  // own_pend spans both waiting in own_data and sitting in the output register.
  always_comb begin
    state_next = state;
    load_own   = 1'b0;
    load_fwd   = 1'b0;
    clr_own    = 1'b0;
    can_fwd    = 1'b0;
    case (state)
      RES_IDLE: can_fwd = !own_pend;
      RES_OWN:  can_fwd = res_ready_i;
      RES_FWD:  can_fwd = res_ready_i && !own_pend;
      default:  can_fwd = 1'b0;
    endcase
    case (state)
      RES_IDLE: begin
        if (own_pend) begin
          load_own   = 1'b1;
          state_next = RES_OWN;
        end else if (res_valid_i) begin
          load_fwd   = 1'b1;
          state_next = RES_FWD;
        end
      end
      RES_OWN: begin
        if (res_ready_i) begin
          clr_own = 1'b1;
          if (res_valid_i) begin
            load_fwd   = 1'b1;
            state_next = RES_FWD;
          end else begin
            state_next = RES_IDLE;
          end
        end
      end
      RES_FWD: begin
        if (res_ready_i) begin
          if (own_pend) begin
            load_own   = 1'b1;
            state_next = RES_OWN;
          end else if (res_valid_i) begin
            load_fwd   = 1'b1;
            state_next = RES_FWD;
          end else begin
            state_next = RES_IDLE;
          end
        end
      end
      default: state_next = RES_IDLE;
    endcase
  end

  assign res_ready_o = can_fwd;
  assign res_valid_o = (state != RES_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RES_IDLE;
      own_pend   <= 1'b0;
      res_data_o <= '0;
    end else begin
      state <= state_next;
      if (hit_rd)       own_pend <= 1'b1;
      else if (clr_own) own_pend <= 1'b0;
      if (load_own)      res_data_o <= own_data;
      else if (load_fwd) res_data_o <= res_data_i;
    end
  end

endmodule

// File: tb/tb_bus_lut_ram.sv
// Directed bench for bus_lut_ram (BASE_ADDR=0x0040, DEPTH=8): posted writes, own reads,
// pass-through, response merging, stalls and reset during traffic.
module tb_bus_lut_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_addr_i, req_data_i, req_addr_o, req_data_o;
  logic        req_rw_i, req_valid_i, req_ready_o, req_rw_o, req_valid_o, req_ready_i;
  logic [15:0] res_data_i, res_data_o;
  logic        res_valid_i, res_ready_o, res_valid_o, res_ready_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_lut_ram #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .BASE_ADDR (16'h0040),
    .DEPTH     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .req_rw_i   (req_rw_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_o (req_addr_o),
    .req_data_o (req_data_o),
    .req_rw_o   (req_rw_o),
    .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i),
    .res_data_i (res_data_i),
    .res_valid_i(res_valid_i),
    .res_ready_o(res_ready_o),
    .res_data_o (res_data_o),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the accept edge with valid dropped.
  task automatic send_req(input logic [15:0] a, input logic [15:0] d, input logic rw);
    logic acc;
    acc = 1'b0;
    req_addr_i  = a;
    req_data_i  = d;
    req_rw_i    = rw;
    req_valid_i = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      #3;
      acc = req_ready_o;
      tick();
    end
    req_valid_i = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_req_timeout addr=%h: req_ready_o stayed 0, required 1", a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({res_valid_o, req_valid_o} !== 2'b00) begin
      failures++;
      $display("FAIL reset_valids: got res=%b req=%b, required 0 0", res_valid_o, req_valid_o);
    end
    checks++;
    if ({res_data_o, req_addr_o, req_data_o, req_rw_o} !== 49'd0) begin
      failures++;
      $display("FAIL reset_regs: got res_data=%h req_addr=%h req_data=%h rw=%b, required all 0",
               res_data_o, req_addr_o, req_data_o, req_rw_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    send_req(16'h0043, 16'hBEEF, 1'b1);
    checks++;
    if (res_valid_o !== 1'b0 || req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL write_no_response: got res_valid=%b req_valid=%b, required 0 0", res_valid_o, req_valid_o);
    end
    send_req(16'h0047, 16'h7777, 1'b1);
    send_req(16'h0043, 16'h0000, 1'b0);
    checks++;
    if (res_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL read_latency_early: got res_valid=%b, required 0", res_valid_o);
    end
    tick();
    checks++;
    if (res_valid_o !== 1'b1 || res_data_o !== 16'hBEEF) begin
      failures++;
      $display("FAIL read_back_43: got valid=%b data=%h, required 1 beef", res_valid_o, res_data_o);
    end
    checks++;
    if (req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL hit_not_forwarded: got req_valid_o=%b, required 0", req_valid_o);
    end
    tick();
    checks++;
    if (res_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL read_drained: got res_valid=%b, required 0", res_valid_o);
    end
    send_req(16'h0047, 16'h0000, 1'b0);
    tick();
    checks++;
    if (res_valid_o !== 1'b1 || res_data_o !== 16'h7777) begin
      failures++;
      $display("FAIL read_back_last: got valid=%b data=%h, required 1 7777", res_valid_o, res_data_o);
    end
    tick();
  endtask

  task automatic test_miss();
    send_req(16'h0048, 16'h5A5A, 1'b0);
    checks++;
    if ({req_valid_o, req_addr_o, req_data_o, req_rw_o} !== {1'b1, 16'h0048, 16'h5A5A, 1'b0}) begin
      failures++;
      $display("FAIL miss_above: got v=%b a=%h d=%h rw=%b, required 1 0048 5a5a 0",
               req_valid_o, req_addr_o, req_data_o, req_rw_o);
    end
    send_req(16'h003F, 16'hC3C3, 1'b1);
    checks++;
    if ({req_valid_o, req_addr_o, req_data_o, req_rw_o} !== {1'b1, 16'h003F, 16'hC3C3, 1'b1}) begin
      failures++;
      $display("FAIL miss_below: got v=%b a=%h d=%h rw=%b, required 1 003f c3c3 1",
               req_valid_o, req_addr_o, req_data_o, req_rw_o);
    end
    tick();
    checks++;
    if (req_valid_o !== 1'b0 || res_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL miss_drain: got req_valid=%b res_valid=%b, required 0 0", req_valid_o, res_valid_o);
    end
  endtask

  task automatic test_merge();
    send_req(16'h0043, 16'h0000, 1'b0);
    res_data_i  = 16'h1234;
    res_valid_i = 1'b1;
    #1;
    checks++;
    if (res_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL merge_ready_blocked: got res_ready_o=%b, required 0", res_ready_o);
    end
    tick();
    checks++;
    if (res_valid_o !== 1'b1 || res_data_o !== 16'hBEEF) begin
      failures++;
      $display("FAIL merge_own_first: got valid=%b data=%h, required 1 beef", res_valid_o, res_data_o);
    end
    checks++;
    if (res_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL merge_ready_open: got res_ready_o=%b, required 1", res_ready_o);
    end
    tick();
    res_valid_i = 1'b0;
    checks++;
    if (res_valid_o !== 1'b1 || res_data_o !== 16'h1234) begin
      failures++;
      $display("FAIL merge_fwd_second: got valid=%b data=%h, required 1 1234", res_valid_o, res_data_o);
    end
    tick();
    checks++;
    if (res_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL merge_idle: got res_valid=%b, required 0", res_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    res_ready_i = 1'b0;
    send_req(16'h0047, 16'h0000, 1'b0);
    tick();
    req_addr_i  = 16'h0043;
    req_rw_i    = 1'b0;
    req_valid_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL second_read_stalled: got req_ready_o=%b, required 0", req_ready_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (res_valid_o !== 1'b1 || res_data_o !== 16'h7777 || req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d: got valid=%b data=%h req_ready=%b, required 1 7777 0",
                 i, res_valid_o, res_data_o, req_ready_o);
      end
    end
    res_ready_i = 1'b1;
    tick();
    checks++;
    if (res_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: got res_valid=%b req_ready=%b, required 0 1", res_valid_o, req_ready_o);
    end
    tick();
    req_valid_i = 1'b0;
    tick();
    checks++;
    if (res_valid_o !== 1'b1 || res_data_o !== 16'hBEEF) begin
      failures++;
      $display("FAIL second_read_data: got valid=%b data=%h, required 1 beef", res_valid_o, res_data_o);
    end
    tick();
  endtask

  task automatic test_downstream_stall();
    req_ready_i = 1'b0;
    send_req(16'h0100, 16'hA1A1, 1'b1);
    req_addr_i = 16'h0044;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL stall_hit_ready: got req_ready_o=%b, required 1", req_ready_o);
    end
    req_addr_i  = 16'h0200;
    req_data_i  = 16'hB2B2;
    req_rw_i    = 1'b0;
    req_valid_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_miss_ready: got req_ready_o=%b, required 0", req_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({req_valid_o, req_addr_o, req_data_o, req_rw_o} !== {1'b1, 16'h0100, 16'hA1A1, 1'b1}) begin
        failures++;
        $display("FAIL stall_stable_%0d: got v=%b a=%h d=%h rw=%b, required 1 0100 a1a1 1",
                 i, req_valid_o, req_addr_o, req_data_o, req_rw_o);
      end
    end
    req_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    checks++;
    if ({req_valid_o, req_addr_o, req_data_o, req_rw_o} !== {1'b1, 16'h0200, 16'hB2B2, 1'b0}) begin
      failures++;
      $display("FAIL stall_next: got v=%b a=%h d=%h rw=%b, required 1 0200 b2b2 0",
               req_valid_o, req_addr_o, req_data_o, req_rw_o);
    end
    tick();
    checks++;
    if (req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_drained: got req_valid_o=%b, required 0", req_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    req_ready_i = 1'b0;
    res_ready_i = 1'b0;
    send_req(16'h0300, 16'hD4D4, 1'b1);
    send_req(16'h0047, 16'h0000, 1'b0);
    tick();
    checks++;
    if (res_valid_o !== 1'b1 || req_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_busy: got res_valid=%b req_valid=%b, required 1 1", res_valid_o, req_valid_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid_o !== 1'b0 || req_valid_o !== 1'b0 || res_data_o !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset: got res_valid=%b req_valid=%b res_data=%h, required 0 0 0000",
               res_valid_o, req_valid_o, res_data_o);
    end
    tick();
    tick();
    rst_n       = 1'b1;
    req_ready_i = 1'b1;
    res_ready_i = 1'b1;
    tick();
    send_req(16'h0047, 16'h0000, 1'b0);
    tick();
    checks++;
    if (res_valid_o !== 1'b1 || res_data_o !== 16'h7777) begin
      failures++;
      $display("FAIL post_reset_read: got valid=%b data=%h, required 1 7777", res_valid_o, res_data_o);
    end
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_rw_i    = 1'b0;
    req_valid_i = 1'b0;
    req_ready_i = 1'b1;
    res_data_i  = '0;
    res_valid_i = 1'b0;
    res_ready_i = 1'b1;
    #1;
    test_reset();
    test_write_read();
    test_miss();
    test_merge();
    test_back_to_back();
    test_downstream_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
